// File: rtl/ro_sampler.sv
// Ring-oscillator entropy consumer: synchronizes the oscillator output, samples it,
// debiases it with a von Neumann corrector and delivers packed words over valid/ready.
module ro_sampler #(
  parameter int WIDTH       = 8,
  parameter int DIVIDE      = 4,
  parameter int WARMUP      = 16,
  parameter int STUCK_LIMIT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             ro_signal,
  output logic             ro_stop,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             stuck
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = $clog2(DIVIDE);
  localparam int WRM_W = $clog2(WARMUP + 1);
  localparam int RUN_W = $clog2(STUCK_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIVIDE - 1);
  localparam logic [WRM_W-1:0] WRM_LAST  = WRM_W'(WARMUP - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STUCK_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAIL} state_t;

  state_t            state_q;
  logic              sync1_q, s2_q;
  logic [WRM_W-1:0]  warm_q;
  logic [DIV_W-1:0]  div_q;
  logic              pair_have_q, pair_first_q;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [RUN_W-1:0]  run_len_q, run_len_d;
  logic              last_q;
  logic [WIDTH-1:0]  data_q;
  logic              valid_q, stuck_q, ro_stop_q;

  logic sample_take, emit, load, xfer, stuck_hit;

  always_comb begin
    sample_take = (state_q == S_RUN) && enable && (div_q == DIV_LAST);
    emit        = sample_take && pair_have_q && (pair_first_q != s2_q);
    load        = (bit_cnt_q == CNT_FULL) && (!valid_q || ready);
    xfer        = valid_q && ready;

    run_len_d = run_len_q;
    if (sample_take) begin
      if (run_len_q == '0 || s2_q != last_q) run_len_d = RUN_W'(1);
      else                                   run_len_d = run_len_q + 1'b1;
    end
    stuck_hit = sample_take && (run_len_d == RUN_LIMIT);

    // A bit arriving on the same edge a word leaves the shift register starts the next word.
    shift_d   = shift_q;
    bit_cnt_d = load ? '0 : bit_cnt_q;
    if (emit) begin
      if (load) begin
        shift_d   = {{(WIDTH-1){1'b0}}, pair_first_q};
        bit_cnt_d = CNT_W'(1);
      end else if (bit_cnt_q != CNT_FULL) begin
        shift_d   = {shift_q[WIDTH-2:0], pair_first_q};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      s2_q         <= 1'b0;
      warm_q       <= '0;
      div_q        <= '0;
      pair_have_q  <= 1'b0;
      pair_first_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      run_len_q    <= '0;
      last_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      ro_stop_q    <= 1'b1;
    end else begin
      sync1_q <= ro_signal;
      s2_q    <= sync1_q;

      if (load) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;

      // Later assignments in the state cases override the datapath defaults above.
      case (state_q)
        S_IDLE: begin
          if (enable && !stuck_q) begin
            state_q   <= S_WARMUP;
            ro_stop_q <= 1'b0;
          end
        end
        S_WARMUP: begin
          if (!enable) begin
            state_q   <= S_IDLE;
            ro_stop_q <= 1'b1;
            warm_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end else if (warm_q == WRM_LAST) begin
            state_q <= S_RUN;
            warm_q  <= '0;
          end else begin
            warm_q <= warm_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!enable) begin
            state_q      <= S_IDLE;
            ro_stop_q    <= 1'b1;
            div_q        <= '0;
            pair_have_q  <= 1'b0;
            pair_first_q <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            run_len_q    <= '0;
            last_q       <= 1'b0;
          end else if (stuck_hit) begin
            state_q      <= S_FAIL;
            ro_stop_q    <= 1'b1;
            stuck_q      <= 1'b1;
            valid_q      <= 1'b0;
            div_q        <= '0;
            pair_have_q  <= 1'b0;
            pair_first_q <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            run_len_q    <= '0;
          end else begin
            div_q <= sample_take ? '0 : div_q + 1'b1;
            if (sample_take) begin
              last_q    <= s2_q;
              run_len_q <= run_len_d;
              if (pair_have_q) begin
                pair_have_q <= 1'b0;
              end else begin
                pair_have_q  <= 1'b1;
                pair_first_q <= s2_q;
              end
            end
          end
        end
        S_FAIL: begin
          ro_stop_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ro_stop = ro_stop_q;
  assign data    = data_q;
  assign valid   = valid_q;
  assign stuck   = stuck_q;

endmodule

// File: tb/tb_ro_sampler.sv
// Randomized and directed bench for ro_sampler; expected words come from a
// pair-by-pair von Neumann model of the raw sample stream.
module tb_ro_sampler;

  localparam int W = 8;
  localparam int D = 4;
  localparam int WU = 16;
  localparam int LIM = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         ro_signal = 1'b0;
  logic         ro_stop;
  logic [W-1:0] data;
  logic         valid;
  logic         ready = 1'b0;
  logic         stuck;

  ro_sampler #(.WIDTH(W), .DIVIDE(D), .WARMUP(WU), .STUCK_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset), .enable(enable), .ro_signal(ro_signal),
    .ro_stop(ro_stop), .data(data), .valid(valid), .ready(ready), .stuck(stuck)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int r0 = 0;
  int first_valid = -1;
  int valid_hi = 0;
  bit samp_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: pair raw samples, keep the first of each unequal pair, pack MSB-first.
  task automatic build_expected();
    logic [W-1:0] w = '0;
    int nb = 0;
    exp_q.delete();
    for (int i = 0; i + 1 < samp_q.size(); i += 2) begin
      if (samp_q[i] != samp_q[i+1]) begin
        w = {w[W-2:0], samp_q[i]};
        nb++;
        if (nb == W) begin
          exp_q.push_back(w);
          nb = 0;
        end
      end
    end
  endtask

  task automatic add_word(input logic [W-1:0] v, input bit with_equal);
    for (int i = W - 1; i >= 0; i--) begin
      samp_q.push_back(v[i]);
      samp_q.push_back(!v[i]);
      if (with_equal && i > 0) begin
        samp_q.push_back(i[0]);
        samp_q.push_back(i[0]);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    ro_signal = 1'($urandom);
    reset = 1'b1;
    #1;
    check("rst_ro_stop", 32'(ro_stop), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    enable = 1'b0;
    ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Leaves the caller #1 after the edge that enters RUN.
  task automatic start_run();
    got_q.delete();
    first_valid = -1;
    valid_hi = 0;
    @(negedge clock);
    check("idle_ro_stop", 32'(ro_stop), 32'd1);
    enable = 1'b1;
    @(posedge clock); #1;
    check("warm_ro_stop", 32'(ro_stop), 32'd0);
    repeat (WU) @(posedge clock);
    #1;
    r0 = cyc;
  endtask

  // Sample k (1-based) is taken on edge r0+D*k; drive it so it reaches s2 in time.
  task automatic drive_run(input int ncyc, input int rmode);
    int age = 0;
    for (int t = 1; t <= ncyc; t++) begin
      @(posedge clock); #1;
      if (t % D == 1 && (t + D - 1) / D <= samp_q.size())
        ro_signal = samp_q[(t + D - 1) / D - 1];
      age = valid ? age + 1 : 0;
      case (rmode)
        0: ready = 1'b1;
        1: ready = (age > 3) ? 1'b1 : 1'($urandom_range(0, 1));
        default: ready = 1'b0;
      endcase
    end
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    fork
      begin : collector
        logic pv, px;
        logic [W-1:0] pd;
        pv = 1'b0; px = 1'b0; pd = '0;
        forever begin
          @(negedge clock);
          if (!reset) begin
            if (valid) begin
              valid_hi++;
              if (first_valid < 0) first_valid = cyc;
            end
            if (pv && !px && valid) check("data_hold", 32'(data), 32'(pd));
            if (valid && ready) got_q.push_back(data);
          end
          pv = valid; pd = data; px = valid && ready;
        end
      end
    join_none

    #2;
    do_reset();

    // Eight unequal pairs -> 0xA5, first valid 2*W*D+1 cycles after RUN entry
    samp_q.delete();
    add_word(8'hA5, 1'b0);
    build_expected();
    start_run();
    drive_run(samp_q.size() * D + 10, 0);
    compare_words("a5");
    if (got_q.size() > 0) check("a5_value", 32'(got_q[0]), 32'hA5);
    check("a5_latency", 32'(first_valid - r0), 32'(2 * W * D + 1));
    check("a5_valid_cycles", 32'(valid_hi), 32'd1);

    // Same word with equal pairs interleaved
    do_reset();
    samp_q.delete();
    add_word(8'hA5, 1'b1);
    build_expected();
    start_run();
    drive_run(samp_q.size() * D + 10, 0);
    compare_words("a5eq");
    if (got_q.size() > 0) check("a5eq_value", 32'(got_q[0]), 32'hA5);
    check("a5eq_latency", 32'(first_valid - r0), 32'(2 * W * D + 1 + 7 * 2 * D));

    // Backpressure: three words while ready is low
    do_reset();
    samp_q.delete();
    add_word(8'h0F, 1'b0);
    add_word(8'hF0, 1'b0);
    add_word(8'h33, 1'b0);
    start_run();
    drive_run(samp_q.size() * D + 8, 2);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_data", 32'(data), 32'h0F);
    ready = 1'b1;
    @(posedge clock); #1;
    ready = 1'b0;
    check("bp_pulse1_valid", 32'(valid), 32'd1);
    check("bp_pulse1_data", 32'(data), 32'hF0);
    repeat (3) @(posedge clock);
    #1;
    ready = 1'b1;
    @(posedge clock); #1;
    ready = 1'b0;
    check("bp_pulse2_valid", 32'(valid), 32'd0);
    check("bp_pulse2_data", 32'(data), 32'hF0);
    exp_q.delete();
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hF0);
    repeat (4) @(posedge clock);
    compare_words("bp");

    // Stuck source
    do_reset();
    samp_q.delete();
    ro_signal = 1'b1;
    start_run();
    drive_run(LIM * D - 1, 0);
    check("stuck_before", 32'(stuck), 32'd0);
    check("stuck_before_ro_stop", 32'(ro_stop), 32'd0);
    @(posedge clock); #1;
    check("stuck_flag", 32'(stuck), 32'd1);
    check("stuck_ro_stop", 32'(ro_stop), 32'd1);
    check("stuck_valid", 32'(valid), 32'd0);
    enable = 1'b0;
    repeat (3) @(posedge clock);
    enable = 1'b1;
    repeat (WU + 8) @(posedge clock);
    #1;
    check("stuck_sticky", 32'(stuck), 32'd1);
    check("stuck_hold_ro_stop", 32'(ro_stop), 32'd1);

    // Enable drop after five bits, then a fresh word
    do_reset();
    samp_q.delete();
    for (int i = 0; i < 5; i++) begin
      samp_q.push_back(i[0] ? 1'b0 : 1'b1);
      samp_q.push_back(i[0] ? 1'b1 : 1'b0);
    end
    start_run();
    drive_run(5 * 2 * D, 0);
    enable = 1'b0;
    @(posedge clock); #1;
    check("drop_ro_stop", 32'(ro_stop), 32'd1);
    check("drop_valid", 32'(valid), 32'd0);
    repeat (5) @(posedge clock);
    samp_q.delete();
    add_word(8'h3C, 1'b0);
    build_expected();
    start_run();
    drive_run(samp_q.size() * D + 10, 0);
    compare_words("fresh");
    check("fresh_latency", 32'(first_valid - r0), 32'(2 * W * D + 1));

    // Randomized raw streams with random consumer stalls
    for (int it = 0; it < 3; it++) begin
      bit last = 1'b0;
      int run = 0;
      do_reset();
      samp_q.delete();
      for (int i = 0; i < 240; i++) begin
        bit b = 1'($urandom_range(0, 1));
        if (i > 0 && b == last && run >= 8) b = !b;
        run = (i > 0 && b == last) ? run + 1 : 1;
        last = b;
        samp_q.push_back(b);
      end
      build_expected();
      start_run();
      drive_run(samp_q.size() * D + 30, 1);
      compare_words("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
